tdes_round_ctrl: RTL
====================

Name: tdes_round_ctrl

Overview:
Sequencer for the iterative single-round DES/TDES datapath: one Feistel round per cycle, 16 rounds per DES stage, three stages for TDES EDE. Owns the block-level valid/ready handshake, stage/round counters and subkey index generation. Drives datapath strobes for IP load, round enable, inter-stage L/R swap, and final-permutation capture.

Parameters:
STAGES, 3, number of DES stages; legal values 1 (single DES) or 3 (TDES EDE). Any other value is an elaboration error.
ROUNDS, 16, rounds per stage; fixed by DES and not to be overridden.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream block valid
in_ready  output  1  controller can accept a block
dec_i  input  1  0 = encrypt, 1 = decrypt; sampled on accept
load_o  output  1  datapath loads IP(pt) into L/R
round_en_o  output  1  datapath performs one Feistel round
stage_swap_o  output  1  datapath applies inter-stage L/R swap (FP·IP cancel)
dec_stage_o  output  1  current stage direction (1 = D)
key_sel_o  output  2  key for current stage: 0 = K1, 1 = K2, 2 = K3
subkey_idx_o  output  4  subkey index 0..15 for current round
round_o  output  4  current round 0..15
stage_o  output  2  current stage 0..STAGES-1
out_valid  output  1  FP(R16,L16) result valid
out_ready  input  1  downstream accepts result
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state IDLE; in_ready=1; out_valid=0, load_o=0, round_en_o=0, stage_swap_o=0, busy_o=0; round_o=0, stage_o=0, dec_stage_o=0, key_sel_o=0, subkey_idx_o=0; latched dec=0.
- States: IDLE, ROUND, SWAP, DONE.
- IDLE: in_ready=1. load_o = in_valid (combinational). On in_valid&in_ready: latch dec_i, round=0, stage=0, go to ROUND.
- ROUND: round_en_o=1. Each cycle round++. When round=15:
  - stage<STAGES-1: go to SWAP.
  - otherwise: go to DONE.
- SWAP: stage_swap_o=1 for one cycle. Then stage++, round=0, return to ROUND.
- DONE: out_valid=1 and held until out_ready. On out_valid&out_ready:
  - in_ready is not asserted in DONE, so there is no same-cycle re-accept.
  - Go to IDLE. The next accept is possible one cycle later.
- Latency for STAGES=3, with the accept edge in cycle 0:
  - round_en_o in cycles 1–16, 18–33, 35–50.
  - stage_swap_o in cycles 17 and 34.
  - out_valid from cycle 51.
- Latency for STAGES=1: out_valid from cycle 17.
- Stage direction (dec_stage_o) and key (key_sel_o):
  - TDES encrypt: E/K1, D/K2, E/K3.
  - TDES decrypt: D/K3, E/K2, D/K1.
  - STAGES=1: dec_stage_o = latched dec, key_sel_o = 0.
- subkey_idx_o = round when dec_stage_o=0, else 15-round (4-bit, no wrap ambiguity).
- Strobes are mutually exclusive: load_o, round_en_o and stage_swap_o never overlap.
- In_valid while busy is ignored and not consumed; dec_i is ignored outside acceptance.
- Reset mid-operation: immediate return to reset values; partial block discarded; no out_valid.
- Back-pressure: DONE holds indefinitely; counters and outputs stay frozen while waiting.

Optional Feature:
TDES_ABORT_EN:
- Defined: adds input abort_i (1 bit). abort_i=1 in ROUND, SWAP or DONE forces IDLE on the next edge, counters cleared, out_valid dropped without handshake. abort_i has priority over out_ready. Ignored in IDLE.
- Undefined: port absent; a block always completes.

Decomposition:
- Package tdes_pkg holds:
  - state enum {IDLE, ROUND, SWAP, DONE};
  - constants ROUNDS=16 and KEY_K1/K2/K3 = 0/1/2;
  - the stage-to-(dec, key_sel) mapping function.
- One sub-module, tdes_round_cnt: round/stage counters with clear/inc/stage-advance and last-round/last-stage flags. The FSM and decode stay in the top.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, all strobes 0, out_valid=0. Release -> first accept loads.
- TDES encrypt, out_ready=1, STAGES=3:
  - round_en_o count = 48; stage_swap_o in cycles 17 and 34; out_valid in cycle 51.
  - key_sel sequence 0,1,2; dec_stage 0,1,0; subkey_idx 0..15, 15..0, 0..15.
- TDES decrypt (dec_i=1): key_sel 2,1,0; dec_stage 1,0,1; subkey_idx 15..0, 0..15, 15..0.
- Back-pressure: out_ready=0 for 20 cycles after out_valid -> out_valid held, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE, next accept one cycle later.
- Mid-operation reset at cycle 25 -> all outputs return to reset values asynchronously; no out_valid follows.
- STAGES=1 run -> 16 round_en_o, no stage_swap_o, out_valid in cycle 17. With TDES_ABORT_EN: abort_i at cycle 20 -> IDLE in cycle 21, no out_valid.

Source files
------------

// File: rtl/tdes_pkg.sv
// tdes_pkg: shared state encoding, round/key constants and stage-to-(direction, key) mapping
package tdes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, SWAP, DONE} state_t;
  localparam int ROUNDS = 16;
  localparam logic [1:0] KEY_K1 = 2'd0;
  localparam logic [1:0] KEY_K2 = 2'd1;
  localparam logic [1:0] KEY_K3 = 2'd2;
  // Returns {dec_stage, key_sel}: EDE encrypt is E/K1,D/K2,E/K3; decrypt runs it backwards.
  function automatic logic [2:0] stage_map(input logic [1:0] stage, input logic dec, input int stages);
    logic mid;
    mid = stage == 2'd1;
    if (stages == 1) return {dec, KEY_K1};
    return dec ? {!mid, stage == 2'd0 ? KEY_K3 : mid ? KEY_K2 : KEY_K1}
               : {mid, stage == 2'd0 ? KEY_K1 : mid ? KEY_K2 : KEY_K3};
  endfunction
endpackage

// File: rtl/tdes_round_cnt.sv
// tdes_round_cnt: round/stage counters for the iterative DES sequencer
// Ports: clk, rst_n (async active-low); clr zeroes both counters, adv moves to round 0
// of the next stage, inc advances the round; round_o/stage_o counts, last_* flags.
module tdes_round_cnt
  import tdes_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       adv,
  output logic [3:0] round_o,
  output logic [1:0] stage_o,
  output logic       last_round_o,
  output logic       last_stage_o
);
  logic [3:0] r_round;
  logic [1:0] r_stage;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= '0;
      r_stage <= '0;
    end else if (clr) begin
      r_round <= '0;
      r_stage <= '0;
    end else if (adv) begin
      r_round <= '0;
      r_stage <= r_stage + 2'd1;
    end else if (inc) begin
      r_round <= r_round + 4'd1;
    end
  end
  assign round_o      = r_round;
  assign stage_o      = r_stage;
  assign last_round_o = r_round == 4'(ROUNDS - 1);
  assign last_stage_o = r_stage == 2'(STAGES - 1);
endmodule

// File: rtl/tdes_round_ctrl.sv
// tdes_round_ctrl: one-round-per-cycle DES/TDES sequencer with block handshake and subkey indexing
// Ports: clk, rst_n (async active-low); in_valid/in_ready/dec_i upstream; out_valid/out_ready
// downstream; load_o, round_en_o, stage_swap_o datapath strobes; dec_stage_o, key_sel_o,
// subkey_idx_o, round_o, stage_o decode; busy_o. Macro TDES_ABORT_EN adds abort_i.
module tdes_round_ctrl
  import tdes_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef TDES_ABORT_EN
  input  logic       abort_i,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       dec_i,
  output logic       load_o,
  output logic       round_en_o,
  output logic       stage_swap_o,
  output logic       dec_stage_o,
  output logic [1:0] key_sel_o,
  output logic [3:0] subkey_idx_o,
  output logic [3:0] round_o,
  output logic [1:0] stage_o,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy_o
);
  if ((STAGES != 1 && STAGES != 3) || ROUNDS != 16) begin : g_bad_cfg
    $error("tdes_round_ctrl: STAGES must be 1 or 3 and ROUNDS must be 16");
  end
  state_t     r_state, w_nxt;
  logic       r_dec, w_clr, w_inc, w_adv, w_last_round, w_last_stage, w_abort;
  logic [2:0] w_map;
`ifdef TDES_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && in_valid) r_dec <= dec_i;
    end
  end
  // The last round does not increment, so DONE shows round 15 of the final stage.
  always_comb begin
    w_nxt = r_state;
    w_clr = 1'b0;
    w_inc = 1'b0;
    w_adv = 1'b0;
    case (r_state)
      IDLE:  if (in_valid) begin
        w_nxt = ROUND;
        w_clr = 1'b1;
      end
      ROUND: if (w_last_round) w_nxt = w_last_stage ? DONE : SWAP;
             else w_inc = 1'b1;
      SWAP:  begin
        w_nxt = ROUND;
        w_adv = 1'b1;
      end
      DONE:  if (out_ready) begin
        w_nxt = IDLE;
        w_clr = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_abort && r_state != IDLE) begin
      w_nxt = IDLE;
      w_clr = 1'b1;
    end
  end
  tdes_round_cnt #(.STAGES(STAGES)) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (w_clr),
    .inc          (w_inc),
    .adv          (w_adv),
    .round_o      (round_o),
    .stage_o      (stage_o),
    .last_round_o (w_last_round),
    .last_stage_o (w_last_stage)
  );
  assign w_map        = stage_map(stage_o, r_dec, STAGES);
  assign in_ready     = r_state == IDLE;
  // Gated by rst_n so the strobe stays low while reset is held with in_valid high.
  assign load_o       = in_ready && in_valid && rst_n;
  assign round_en_o   = r_state == ROUND;
  assign stage_swap_o = r_state == SWAP;
  assign out_valid    = r_state == DONE;
  assign busy_o       = r_state != IDLE;
  assign dec_stage_o  = w_map[2];
  assign key_sel_o    = w_map[1:0];
  assign subkey_idx_o = dec_stage_o ? 4'd15 - round_o : round_o;
endmodule
